corner_frame_ctrl: RTL and testbench

Frame-level controller for the pink-corner detector. It holds the HPS-written detector thresholds in shadow registers and applies them atomically at the VGA_VS falling edge, so the detector never runs a frame with mixed thresholds. It also snapshots the detector's four per-frame corner coordinates one frame boundary later and publishes them to the HPS side through a valid/ack mailbox. Optional settle frames follow each config change, and a sticky overrun flag reports dropped frames.

---
 rtl/corner_ctrl_pkg.sv | 52 +++++
 rtl/corner_cfg_shadow.sv | 79 +++++++
 rtl/corner_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_corner_frame_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corner_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// corner_ctrl_pkg
// Shared constants and types for the pink-corner frame controller:
//   - configuration register addresses
//   - frame FSM state encoding
//   - bit offsets of the eight packed corner coordinates
//   - threshold bundle type used between the shadow block and the top
// -----------------------------------------------------------------------------
package corner_ctrl_pkg;

    localparam int COORD_W   = 10;
    localparam int THR_W     = 8;
    localparam int HIST_W    = 2;
    localparam int CORNERS_W = 8 * COORD_W;

    // Configuration register map
    localparam logic [2:0] CFG_ADDR_CB    = 3'd0;
    localparam logic [2:0] CFG_ADDR_CR    = 3'd1;
    localparam logic [2:0] CFG_ADDR_HIST  = 3'd2;
    localparam logic [2:0] CFG_ADDR_XDIFF = 3'd3;
    localparam logic [2:0] CFG_ADDR_YDIFF = 3'd4;
    localparam logic [2:0] CFG_ADDR_CTRL  = 3'd5;

    // Frame FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // Corner packing: TLx, TLy, TRx, TRy, BLx, BLy, BRx, BRy from LSB upward
    localparam int TLX_LSB = 0;
    localparam int TLY_LSB = 10;
    localparam int TRX_LSB = 20;
    localparam int TRY_LSB = 30;
    localparam int BLX_LSB = 40;
    localparam int BLY_LSB = 50;
    localparam int BRX_LSB = 60;
    localparam int BRY_LSB = 70;

    typedef struct packed {
        logic [THR_W-1:0]  cb;
        logic [THR_W-1:0]  cr;
        logic [HIST_W-1:0] hist;
        logic [THR_W-1:0]  x_diff;
        logic [THR_W-1:0]  y_diff;
    } thr_t;

    // Addresses 0..4 target a threshold register
    function automatic logic is_thr_addr(input logic [2:0] addr);
        return addr <= CFG_ADDR_YDIFF;
    endfunction

endpackage

// File: rtl/corner_cfg_shadow.sv
// -----------------------------------------------------------------------------
// corner_cfg_shadow
// Holds the HPS-written thresholds in a shadow copy and transfers them to the
// active copy on a VS falling edge, so a frame never sees mixed thresholds.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   vs_fall         one-cycle pulse at the VS falling edge
//   cfg_write/addr/wdata  configuration write port
//   active          thresholds currently driven to the detector
//   cfg_pending     shadow written since the last apply
//   apply           pulse: active is loaded from shadow at this clock edge
// -----------------------------------------------------------------------------
module corner_cfg_shadow
    import corner_ctrl_pkg::*;
#(
    parameter logic [7:0] DEF_CB    = 8'd120,
    parameter logic [7:0] DEF_CR    = 8'd120,
    parameter logic [1:0] DEF_HIST  = 2'd2,
    parameter logic [7:0] DEF_XDIFF = 8'd10,
    parameter logic [7:0] DEF_YDIFF = 8'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vs_fall,
    input  logic       cfg_write,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output thr_t       active,
    output logic       cfg_pending,
    output logic       apply
);

    localparam thr_t THR_DEFAULT = '{cb: DEF_CB, cr: DEF_CR, hist: DEF_HIST,
                                     x_diff: DEF_XDIFF, y_diff: DEF_YDIFF};

    thr_t shadow;
    logic thr_write;

    assign thr_write = cfg_write && is_thr_addr(cfg_addr);
    assign apply     = vs_fall && cfg_pending;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; here active copies the shadow value from before
    // a same-cycle write, which is exactly the required ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= THR_DEFAULT;
        end else if (thr_write) begin
            case (cfg_addr)
                CFG_ADDR_CB:    shadow.cb     <= cfg_wdata;
                CFG_ADDR_CR:    shadow.cr     <= cfg_wdata;
                CFG_ADDR_HIST:  shadow.hist   <= cfg_wdata[HIST_W-1:0];
                CFG_ADDR_XDIFF: shadow.x_diff <= cfg_wdata;
                default:        shadow.y_diff <= cfg_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= THR_DEFAULT;
        end else if (apply) begin
            active <= shadow;
        end
    end

    // A write in the apply cycle lands in the shadow after the copy, so the
    // flag must stay set for the following frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_pending <= 1'b0;
        end else if (thr_write) begin
            cfg_pending <= 1'b1;
        end else if (vs_fall) begin
            cfg_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/corner_frame_ctrl.sv
// -----------------------------------------------------------------------------
// corner_frame_ctrl
// Frame-level controller for the pink-corner detector: atomic threshold
// update at VS fall, per-frame corner snapshot one frame boundary later,
// valid/ack mailbox to the HPS, settle frames after config changes and a
// sticky overrun flag.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   VGA_VS                vertical sync (clk domain)
//   cfg_write/addr/wdata  config writes (0-4 thresholds, 5 ctrl)
//   corners_in            detector corners, packed 8 x 10 bit
//   res_ack               consumer acknowledges res_data
//   threshold_*           active thresholds to the detector
//   res_data/res_valid    published snapshot and its valid flag
//   res_overrun           sticky dropped-frame flag
//   cfg_pending           shadow waiting for the next frame
//   frame_count           number of VS falling edges (wraps)
// -----------------------------------------------------------------------------
module corner_frame_ctrl
    import corner_ctrl_pkg::*;
#(
    parameter logic [7:0] DEF_CB        = 8'd120,
    parameter logic [7:0] DEF_CR        = 8'd120,
    parameter logic [1:0] DEF_HIST      = 2'd2,
    parameter logic [7:0] DEF_XDIFF     = 8'd10,
    parameter logic [7:0] DEF_YDIFF     = 8'd10,
    parameter int         SETTLE_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 VGA_VS,
    input  logic                 cfg_write,
    input  logic [2:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    input  logic [CORNERS_W-1:0] corners_in,
    input  logic                 res_ack,
    output logic [THR_W-1:0]     threshold_Cb,
    output logic [THR_W-1:0]     threshold_Cr,
    output logic [HIST_W-1:0]    threshold_history,
    output logic [THR_W-1:0]     threshold_x_diff,
    output logic [THR_W-1:0]     threshold_y_diff,
    output logic [CORNERS_W-1:0] res_data,
    output logic                 res_valid,
    output logic                 res_overrun,
    output logic                 cfg_pending,
    output logic [15:0]          frame_count
);

    logic       vs_prev;
    logic       vs_fall;
    logic [1:0] state;
    logic [1:0] state_next;
    logic [1:0] settle_cnt;
    logic       apply;
    logic       capture;
    logic       publish;
    logic       drop;
    logic       overrun_clear;
    thr_t       active;

    // vs_prev resets low so leaving reset with VS low is not seen as an edge
    assign vs_fall = vs_prev && !VGA_VS;

    corner_cfg_shadow #(
        .DEF_CB    (DEF_CB),
        .DEF_CR    (DEF_CR),
        .DEF_HIST  (DEF_HIST),
        .DEF_XDIFF (DEF_XDIFF),
        .DEF_YDIFF (DEF_YDIFF)
    ) u_cfg_shadow (
        .clk         (clk),
        .reset       (reset),
        .vs_fall     (vs_fall),
        .cfg_write   (cfg_write),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .active      (active),
        .cfg_pending (cfg_pending),
        .apply       (apply)
    );

    assign threshold_Cb      = active.cb;
    assign threshold_Cr      = active.cr;
    assign threshold_history = active.hist;
    assign threshold_x_diff  = active.x_diff;
    assign threshold_y_diff  = active.y_diff;

    // The detector registers its corners in the vs_fall cycle, so sampling is
    // deferred by one WAIT cycle. Edges seen in WAIT/CAPTURE are ignored.
    // NOTE: a default assignment ahead of the case keeps this block purely
    // combinational; without it an uncovered path would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (vs_fall) state_next = ST_WAIT;
            ST_WAIT:    state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign capture       = (state == ST_CAPTURE);
    // An ack in the capture cycle frees the slot for the new snapshot
    assign publish       = capture && (settle_cnt == 2'd0) && (!res_valid || res_ack);
    assign drop          = capture && (settle_cnt == 2'd0) && res_valid && !res_ack;
    assign overrun_clear = cfg_write && (cfg_addr == CFG_ADDR_CTRL) && cfg_wdata[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev     <= 1'b0;
            state       <= ST_IDLE;
            frame_count <= 16'd0;
        end else begin
            vs_prev <= VGA_VS;
            state   <= state_next;
            if (vs_fall) frame_count <= frame_count + 16'd1;
        end
    end

    // A fresh apply restarts the settle window even if a capture is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= 2'd0;
        end else if (apply) begin
            settle_cnt <= 2'(SETTLE_FRAMES);
        end else if (capture && settle_cnt != 2'd0) begin
            settle_cnt <= settle_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_data  <= '0;
            res_valid <= 1'b0;
        end else if (publish) begin
            res_data  <= corners_in;
            res_valid <= 1'b1;
        end else if (res_ack) begin
            res_valid <= 1'b0;
        end
    end

    // Set has priority over a same-cycle software clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_overrun <= 1'b0;
        end else if (drop) begin
            res_overrun <= 1'b1;
        end else if (overrun_clear) begin
            res_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_corner_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_corner_frame_ctrl
// Self-checking bench: directed scenarios with literal expectations, then
// randomized frames, all compared every cycle against a timeline model.
// -----------------------------------------------------------------------------
module tb_corner_frame_ctrl;
    import corner_ctrl_pkg::*;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        VGA_VS;
    logic        cfg_write;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [79:0] corners_in;
    logic        res_ack;
    logic [7:0]  threshold_Cb, threshold_Cr, threshold_x_diff, threshold_y_diff;
    logic [1:0]  threshold_history;
    logic [79:0] res_data;
    logic        res_valid, res_overrun, cfg_pending;
    logic [15:0] frame_count;

    corner_frame_ctrl #(.SETTLE_FRAMES(SETTLE)) dut (
        .clk               (clk),
        .reset             (reset),
        .VGA_VS            (VGA_VS),
        .cfg_write         (cfg_write),
        .cfg_addr          (cfg_addr),
        .cfg_wdata         (cfg_wdata),
        .corners_in        (corners_in),
        .res_ack           (res_ack),
        .threshold_Cb      (threshold_Cb),
        .threshold_Cr      (threshold_Cr),
        .threshold_history (threshold_history),
        .threshold_x_diff  (threshold_x_diff),
        .threshold_y_diff  (threshold_y_diff),
        .res_data          (res_data),
        .res_valid         (res_valid),
        .res_overrun       (res_overrun),
        .cfg_pending       (cfg_pending),
        .frame_count       (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Thresholds as an array indexed by config address; captures scheduled on
    // an absolute cycle timeline (vs_fall cycle + 2).
    logic [7:0]  m_act [5];
    logic [7:0]  m_shd [5];
    bit          m_pending, m_valid, m_ovr, m_vs_prev, m_cap_armed;
    int          m_settle;
    logic [79:0] m_data;
    logic [15:0] m_fc;
    longint      m_cyc = 0;
    longint      m_cap_cycle;

    task automatic model_reset();
        m_act[0] = 8'd120; m_act[1] = 8'd120; m_act[2] = 8'd2;
        m_act[3] = 8'd10;  m_act[4] = 8'd10;
        for (int i = 0; i < 5; i++) m_shd[i] = m_act[i];
        m_pending = 0; m_valid = 0; m_ovr = 0; m_vs_prev = 0;
        m_cap_armed = 0; m_settle = 0; m_data = '0; m_fc = '0; m_cap_cycle = 0;
    endtask

    // Advance the model by one clock edge using the inputs of the ending cycle
    task automatic model_update();
        bit fall, cap, ovr_set;
        fall    = m_vs_prev && !VGA_VS;
        cap     = m_cap_armed && (m_cyc == m_cap_cycle);
        ovr_set = 0;
        if (cap) begin
            if (m_settle != 0) begin
                m_settle--;
                if (res_ack) m_valid = 0;
            end else if (m_valid && !res_ack) begin
                ovr_set = 1;
            end else begin
                m_data  = corners_in;
                m_valid = 1;
            end
        end else if (res_ack) begin
            m_valid = 0;
        end
        if (cfg_write && cfg_addr == 3'd5 && cfg_wdata[0]) m_ovr = 0;
        if (ovr_set) m_ovr = 1;
        if (fall && m_pending) begin
            for (int i = 0; i < 5; i++) m_act[i] = m_shd[i];
            m_settle = SETTLE;
        end
        if (cfg_write && cfg_addr <= 3'd4) begin
            m_shd[cfg_addr] = (cfg_addr == 3'd2) ? {6'd0, cfg_wdata[1:0]} : cfg_wdata;
            m_pending = 1;
        end else if (fall) begin
            m_pending = 0;
        end
        if (fall) begin
            m_fc++;
            if (!(m_cap_armed && m_cyc <= m_cap_cycle)) begin
                m_cap_armed = 1;
                m_cap_cycle = m_cyc + 2;
            end
        end
        m_vs_prev = VGA_VS;
        m_cyc++;
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("threshold_Cb",      threshold_Cb,      m_act[0]);
            check("threshold_Cr",      threshold_Cr,      m_act[1]);
            check("threshold_history", threshold_history, m_act[2]);
            check("threshold_x_diff",  threshold_x_diff,  m_act[3]);
            check("threshold_y_diff",  threshold_y_diff,  m_act[4]);
            check("res_valid",         res_valid,         m_valid);
            check("res_overrun",       res_overrun,       m_ovr);
            check("cfg_pending",       cfg_pending,       m_pending);
            check("frame_count",       frame_count,       m_fc);
            if (m_valid) check("res_data", res_data, m_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // One VS high cycle then VS low; returns n cycles after the vs_fall cycle
    task automatic fall_and_wait(input int n);
        VGA_VS = 1'b1;
        tick();
        VGA_VS = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [79:0] mk_corners(input int tlx, input int tly,
                                                input int brx, input int bry);
        logic [79:0] c;
        c = '0;
        c[TLX_LSB +: COORD_W] = 10'(tlx);
        c[TLY_LSB +: COORD_W] = 10'(tly);
        c[TRX_LSB +: COORD_W] = 10'(tlx + 7);
        c[TRY_LSB +: COORD_W] = 10'(tly + 3);
        c[BLX_LSB +: COORD_W] = 10'(brx - 5);
        c[BLY_LSB +: COORD_W] = 10'(bry - 2);
        c[BRX_LSB +: COORD_W] = 10'(brx);
        c[BRY_LSB +: COORD_W] = 10'(bry);
        return c;
    endfunction

    task automatic check_reset_values();
        check("rst_Cb",      threshold_Cb,      80'd120);
        check("rst_Cr",      threshold_Cr,      80'd120);
        check("rst_history", threshold_history, 80'd2);
        check("rst_x_diff",  threshold_x_diff,  80'd10);
        check("rst_y_diff",  threshold_y_diff,  80'd10);
        check("rst_valid",   res_valid,         80'd0);
        check("rst_overrun", res_overrun,       80'd0);
        check("rst_pending", cfg_pending,       80'd0);
        check("rst_fcount",  frame_count,       80'd0);
        check("rst_data",    res_data,          80'd0);
    endtask

    initial begin
        logic [79:0] c_a, c_b, c_c, c_d;
        reset = 1'b1; VGA_VS = 1'b0; cfg_write = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; corners_in = '0; res_ack = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // Publish with no settle pending: valid at vs_fall+3
        corners_in = mk_corners(100, 50, 300, 200);
        fall_and_wait(2);
        check("pub_valid_early", res_valid, 80'd0);
        tick();
        check("pub_valid", res_valid, 80'd1);
        check("pub_tlx", res_data[9:0], 80'd100);
        check("pub_bry", res_data[79:70], 80'd200);
        res_ack = 1'b1; tick(); res_ack = 1'b0;
        check("ack_clears_valid", res_valid, 80'd0);

        // Two frames without ack: second is dropped
        c_a = mk_corners(11, 22, 333, 444);
        c_b = mk_corners(55, 66, 777, 888);
        corners_in = c_a; fall_and_wait(4);
        corners_in = c_b; fall_and_wait(4);
        check("ovr_set", res_overrun, 80'd1);
        check("ovr_keep_data", res_data, c_a);
        cfg_write = 1'b1; cfg_addr = 3'd5; cfg_wdata = 8'h01; tick(); cfg_write = 1'b0;
        check("ovr_cleared", res_overrun, 80'd0);

        // Ack in the capture cycle frees the slot
        c_c = mk_corners(123, 45, 678, 901);
        corners_in = c_c;
        fall_and_wait(1); tick();
        res_ack = 1'b1; tick(); res_ack = 1'b0;
        check("ack_cap_valid", res_valid, 80'd1);
        check("ack_cap_data", res_data, c_c);
        check("ack_cap_ovr", res_overrun, 80'd0);
        res_ack = 1'b1; tick(); res_ack = 1'b0;

        // Config apply plus settle frames
        cfg_write = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'h50; tick(); cfg_write = 1'b0;
        check("cfg_pending_set", cfg_pending, 80'd1);
        check("cb_not_yet", threshold_Cb, 80'd120);
        fall_and_wait(1);
        check("cb_applied", threshold_Cb, 80'h50);
        check("cfg_pending_clr", cfg_pending, 80'd0);
        tick(); tick();
        check("settle1_nopub", res_valid, 80'd0);
        fall_and_wait(3);
        check("settle2_nopub", res_valid, 80'd0);
        c_d = mk_corners(9, 8, 700, 600);
        corners_in = c_d;
        fall_and_wait(3);
        check("settle_pub_valid", res_valid, 80'd1);
        check("settle_pub_data", res_data, c_d);
        res_ack = 1'b1; tick(); res_ack = 1'b0;

        // Write in the vs_fall cycle waits for the following frame
        VGA_VS = 1'b1; tick();
        VGA_VS = 1'b0; cfg_write = 1'b1; cfg_addr = 3'd1; cfg_wdata = 8'h30;
        tick(); cfg_write = 1'b0;
        check("cr_unchanged", threshold_Cr, 80'd120);
        check("cr_pending", cfg_pending, 80'd1);
        tick(); tick();
        fall_and_wait(1);
        check("cr_applied", threshold_Cr, 80'h30);

        // Reset in CAPTURE with a valid snapshot outstanding
        fall_and_wait(3);
        fall_and_wait(3);
        check("pre_rst_valid", res_valid, 80'd1);
        fall_and_wait(1); tick();
        #2 reset = 1'b1; VGA_VS = 1'b1; model_reset();
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0; VGA_VS = 1'b0;
        repeat (5) tick();
        check("post_rst_nofall", frame_count, 80'd0);
        check("post_rst_nopub", res_valid, 80'd0);
        fall_and_wait(1);
        check("post_rst_fall", frame_count, 80'd1);

        // Randomized frames, including very short ones
        for (int f = 0; f < 300; f++) begin
            int hi, lo;
            hi = $urandom_range(1, 6);
            lo = $urandom_range(1, 8);
            for (int k = 0; k < hi + lo; k++) begin
                VGA_VS     = (k < hi);
                cfg_write  = ($urandom_range(0, 9) == 0);
                cfg_addr   = 3'($urandom_range(0, 7));
                cfg_wdata  = 8'($urandom());
                res_ack    = ($urandom_range(0, 3) == 0);
                corners_in = {16'($urandom()), $urandom(), $urandom()};
                tick();
            end
        end
        cfg_write = 1'b0; res_ack = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
